// File: rtl/spi_reg_responder_if.sv
// SPI pin bundle between an initiator (master) and spi_reg_responder (slave).
interface spi_reg_responder_if;
   logic Sclk;
   logic Ss_n;
   logic Mosi;
   logic Miso;
   logic Miso_oe;

   modport master (output Sclk, output Ss_n, output Mosi, input Miso, input Miso_oe);
   modport slave  (input Sclk, input Ss_n, input Mosi, output Miso, output Miso_oe);
endinterface

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder fronting a 32 x 8 register file with a local fabric port.
// Optional macro SPI_RESP_AUTO_INC_EN: post-increment the address after each data byte.
module spi_reg_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  RESET_VAL   = 8'h00
) (
   input  logic               Clk,
   input  logic               Reset_n,
   spi_reg_responder_if.slave spi,
   input  logic [7:0]         Status,
   input  logic               LocalWe,
   input  logic [4:0]         LocalWAddr,
   input  logic [7:0]         LocalWData,
   input  logic [4:0]         LocalRAddr,
   output logic [7:0]         LocalRData,
   output logic               WrStb,
   output logic [4:0]         WrAddr,
   output logic [7:0]         WrData,
   output logic               Busy
);
   typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;
   state_t state, state_nxt;

   logic [1:0]             rst_sync;
   logic                   rst_n;
   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
   logic                   sclk_s, ss_s, mosi_s, sclk_prev, ss_prev;
   logic                   rise, fall, ss_fall, byte_done;
   logic [2:0]             bit_cnt;
   logic [6:0]             rx_shift;
   logic [7:0]             rx_byte, tx_shift;
   logic [4:0]             addr, addr_inc;
   logic                   miso_oe;
   logic [7:0]             regs [32];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) rst_sync <= '0;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         ss_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.Sclk};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.Ss_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.Mosi};
         sclk_prev <= sclk_s;
         ss_prev   <= ss_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   // Sclk edges only count while selected.
   assign rise      = sclk_s & ~sclk_prev & ~ss_s;
   assign fall      = ~sclk_s & sclk_prev & ~ss_s;
   assign ss_fall   = ~ss_s & ss_prev;
   assign rx_byte   = {rx_shift, mosi_s};
   assign byte_done = rise && (bit_cnt == 3'd7);

`ifdef SPI_RESP_AUTO_INC_EN
   assign addr_inc = addr + 5'd1;
`else
   assign addr_inc = addr;
`endif

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ss_fall) state_nxt = CMD;
         CMD: begin
            if (ss_s)           state_nxt = IDLE;
            else if (byte_done) state_nxt = rx_byte[1] ? WR : RD;
         end
         default: if (ss_s)     state_nxt = IDLE;
      endcase
   end

   assign Busy        = (state != IDLE);
   assign spi.Miso    = miso_oe & tx_shift[7];
   assign spi.Miso_oe = miso_oe;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         addr     <= '0;
         miso_oe  <= 1'b0;
         WrStb    <= 1'b0;
         WrAddr   <= '0;
         WrData   <= '0;
      end else begin
         WrStb <= 1'b0;
         if (state == IDLE) begin
            if (ss_fall) begin
               tx_shift <= Status;
               miso_oe  <= 1'b1;
               bit_cnt  <= '0;
            end
         end else if (ss_s) begin
            tx_shift <= '0;
            miso_oe  <= 1'b0;
            bit_cnt  <= '0;
         end else begin
            if (rise) begin
               rx_shift <= rx_byte[6:0];
               bit_cnt  <= bit_cnt + 3'd1;
               if (byte_done) begin
                  case (state)
                     CMD: addr <= rx_byte[7:3];
                     WR: begin
                        WrStb  <= 1'b1;
                        WrAddr <= addr;
                        WrData <= rx_byte;
                        addr   <= addr_inc;
                     end
                     default: addr <= addr_inc;
                  endcase
               end
            end
            // bit_cnt wraps to 0 on the 8th rise, so the next fall is the byte boundary.
            if (fall) begin
               if (state == RD && bit_cnt == 3'd0) tx_shift <= regs[addr];
               else                                tx_shift <= {tx_shift[6:0], 1'b0};
            end
         end
      end
   end

   // SPI writes commit on the WrStb cycle and take priority on an address clash.
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= RESET_VAL;
         LocalRData <= '0;
      end else begin
         LocalRData <= regs[LocalRAddr];
         if (LocalWe && !(WrStb && LocalWAddr == WrAddr)) regs[LocalWAddr] <= LocalWData;
         if (WrStb) regs[WrAddr] <= WrData;
      end
   end
endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: vector table plus hand-written corner sequences.
module tb_spi_reg_responder;
   localparam int HALF = 5;
`ifdef SPI_RESP_AUTO_INC_EN
   localparam logic [4:0] STEP = 5'd1;
`else
   localparam logic [4:0] STEP = 5'd0;
`endif

   typedef struct {
      logic [4:0] addr;
      logic [2:0] junk;
      logic [7:0] data;
      logic [7:0] status;
   } vec_t;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b1;
   logic [7:0] Status = '0;
   logic       LocalWe = 1'b0;
   logic [4:0] LocalWAddr = '0;
   logic [7:0] LocalWData = '0;
   logic [4:0] LocalRAddr = '0;
   logic [7:0] LocalRData;
   logic       WrStb;
   logic [4:0] WrAddr;
   logic [7:0] WrData;
   logic       Busy;

   int checks = 0;
   int errors = 0;
   logic [12:0] exp_q[$];
   logic [12:0] obs_q[$];
   logic [7:0]  mdl [32];
   logic        oe_bad;
   vec_t        vecs [5];

   spi_reg_responder_if spi ();

   spi_reg_responder #(.SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .spi(spi), .Status(Status),
      .LocalWe(LocalWe), .LocalWAddr(LocalWAddr), .LocalWData(LocalWData),
      .LocalRAddr(LocalRAddr), .LocalRData(LocalRData),
      .WrStb(WrStb), .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy)
   );

   always #10 Clk = ~Clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
         if (WrStb) obs_q.push_back({WrAddr, WrData});
      end
   endtask

   task automatic sb_check(input string name);
      logic [12:0] e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL %s wrstb: got no pulse, expected addr %0d data %h", name, e[12:8], e[7:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               errors++;
               $display("FAIL %s wrstb: got addr %0d data %h, expected addr %0d data %h",
                        name, o[12:8], o[7:0], e[12:8], e[7:0]);
            end
         end
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s wrstb: got addr %0d data %h, expected no pulse", name, o[12:8], o[7:0]);
      end
   endtask

   task automatic sel();
      spi.Ss_n = 1'b0;
      oe_bad = 1'b0;
      tick(HALF);
   endtask

   task automatic desel();
      tick(HALF);
      spi.Ss_n = 1'b1;
      tick(HALF);
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi.Mosi = tx[i];
         tick(HALF);
         spi.Sclk = 1'b1;
         rx[i] = spi.Miso;
         if (!spi.Miso_oe) oe_bad = 1'b1;
         tick(HALF);
         spi.Sclk = 1'b0;
      end
   endtask

   task automatic local_read(input logic [4:0] a, output logic [7:0] d);
      LocalRAddr = a;
      tick(2);
      d = LocalRData;
   endtask

   task automatic spi_write(input logic [4:0] a, input logic [2:0] junk, input logic [7:0] d);
      logic [7:0] rx;
      sel();
      xfer({a, junk[2], 1'b1, junk[0]}, 8, rx);
      exp_q.push_back({a, d});
      mdl[a] = d;
      xfer(d, 8, rx);
      check("wr_miso_zero", rx, 8'h00);
      desel();
   endtask

   task automatic collide(input logic [4:0] sa, input logic [7:0] sd,
                          input logic [4:0] la, input logic [7:0] ld);
      logic [7:0] rx, prev;
      logic       seen;
      prev = mdl[la];
      sel();
      xfer({sa, 3'b010}, 8, rx);
      xfer(sd, 7, rx);
      spi.Mosi = sd[0];
      tick(HALF);
      spi.Sclk = 1'b1;
      exp_q.push_back({sa, sd});
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge Clk);
         #1;
         if (WrStb) begin
            seen = 1'b1;
            obs_q.push_back({WrAddr, WrData});
            LocalWe = 1'b1; LocalWAddr = la; LocalWData = ld; LocalRAddr = la;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL collide_timeout: got no WrStb in 10 cycles, expected one");
      end
      tick(1);
      LocalWe = 1'b0;
      check("collide_rdata_lat1", LocalRData, prev);
      mdl[sa] = sd;
      if (la != sa) mdl[la] = ld;
      tick(1);
      check("collide_rdata_lat2", LocalRData, mdl[la]);
      tick(HALF);
      spi.Sclk = 1'b0;
      desel();
      sb_check("collide");
      local_read(sa, rx);
      check("collide_spi_reg", rx, mdl[sa]);
      local_read(la, rx);
      check("collide_local_reg", rx, mdl[la]);
   endtask

   initial begin
      logic [7:0] rx, r0, r1, r2;
      vecs[0] = '{addr: 5'd5,  junk: 3'b000, data: 8'hC3, status: 8'h81};
      vecs[1] = '{addr: 5'd0,  junk: 3'b101, data: 8'h5A, status: 8'h00};
      vecs[2] = '{addr: 5'd31, junk: 3'b100, data: 8'hA5, status: 8'hFF};
      vecs[3] = '{addr: 5'd12, junk: 3'b001, data: 8'h3C, status: 8'h7E};
      vecs[4] = '{addr: 5'd17, junk: 3'b000, data: 8'hFF, status: 8'h42};
      for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
      spi.Sclk = 1'b0; spi.Ss_n = 1'b1; spi.Mosi = 1'b0;
      oe_bad = 1'b0;

      #5 Reset_n = 1'b0;
      tick(3);
      check("rst_busy", {7'd0, Busy}, 8'h00);
      check("rst_miso_oe", {7'd0, spi.Miso_oe}, 8'h00);
      check("rst_miso", {7'd0, spi.Miso}, 8'h00);
      check("rst_wrstb", {7'd0, WrStb}, 8'h00);
      check("rst_wraddr", {3'd0, WrAddr}, 8'h00);
      check("rst_wrdata", WrData, 8'h00);
      check("rst_rdata", LocalRData, 8'h00);
      Reset_n = 1'b1;
      tick(4);
      local_read(5'd9, rx);
      check("rst_reg9", rx, 8'h00);

      for (int v = 0; v < 5; v++) begin
         spi_write(vecs[v].addr, vecs[v].junk, vecs[v].data);
         sb_check("vec_write");
         local_read(vecs[v].addr, rx);
         check("vec_local_rd", rx, vecs[v].data);
         Status = vecs[v].status;
         sel();
         xfer({vecs[v].addr, vecs[v].junk[2], 1'b0, vecs[v].junk[0]}, 8, r0);
         xfer(8'h00, 8, r1);
         xfer(8'h00, 8, r2);
         check("vec_busy", {7'd0, Busy}, 8'h01);
         desel();
         check("vec_status", r0, vecs[v].status);
         check("vec_rd_byte0", r1, mdl[vecs[v].addr]);
         check("vec_rd_byte1", r2, mdl[vecs[v].addr + STEP]);
         check("vec_oe_active", {7'd0, oe_bad}, 8'h00);
         check("vec_oe_idle", {7'd0, spi.Miso_oe}, 8'h00);
         check("vec_miso_idle", {7'd0, spi.Miso}, 8'h00);
         check("vec_busy_idle", {7'd0, Busy}, 8'h00);
         sb_check("vec_read");
      end

      // aborted write: command for reg 2 plus five data bits
      sel();
      xfer(8'h12, 8, rx);
      xfer(8'hFF, 5, rx);
      desel();
      tick(4);
      sb_check("abort");
      local_read(5'd2, rx);
      check("abort_reg2", rx, 8'h00);
      check("abort_busy", {7'd0, Busy}, 8'h00);

      collide(5'd5, 8'h77, 5'd5, 8'h11);
      collide(5'd9, 8'h99, 5'd10, 8'h44);

      // multi-byte write to reg 31
      sel();
      xfer(8'hFA, 8, rx);
      exp_q.push_back({5'd31, 8'h01});
      mdl[5'd31] = 8'h01;
      xfer(8'h01, 8, rx);
      exp_q.push_back({5'd31 + STEP, 8'h02});
      mdl[5'd31 + STEP] = 8'h02;
      xfer(8'h02, 8, rx);
      desel();
      sb_check("multi");
      local_read(5'd31, rx);
      check("multi_reg31", rx, mdl[31]);
      local_read(5'd0, rx);
      check("multi_reg0", rx, mdl[0]);

      // reset in the middle of the command byte
      local_read(5'd5, rx);
      check("pre_rst_rdata", rx, 8'h77);
      Status = 8'h80;
      sel();
      xfer(8'h2A, 4, rx);
      check("midrst_busy_pre", {7'd0, Busy}, 8'h01);
      Reset_n = 1'b0;
      #1;
      check("midrst_busy", {7'd0, Busy}, 8'h00);
      check("midrst_miso_oe", {7'd0, spi.Miso_oe}, 8'h00);
      check("midrst_miso", {7'd0, spi.Miso}, 8'h00);
      check("midrst_wrstb", {7'd0, WrStb}, 8'h00);
      check("midrst_rdata", LocalRData, 8'h00);
      tick(3);
      spi.Ss_n = 1'b1;
      Reset_n = 1'b1;
      tick(5);
      for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
      for (int i = 0; i < 32; i++) begin
         local_read(5'(i), rx);
         check("midrst_reg", rx, mdl[i]);
      end
      sb_check("midrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: got no finish, expected finish before 5 ms");
      $fatal(1);
   end
endmodule
